// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: round-robin arbiter that queues button press events into a valid/ready FIFO.
// Optional DROP_CNT_EN adds a saturating counter of coalesced presses on port drop_cnt.
module btn_event_arbiter #(
   parameter int N_BTN      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_BTN-1:0]              btn_pulse,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [$clog2(N_BTN)-1:0]      evt_idx,
   output logic [N_BTN-1:0]              pending,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef DROP_CNT_EN
   ,
   output logic [7:0]                    drop_cnt
`endif
);
   localparam int IDX_W = $clog2(N_BTN);
   localparam int TW    = IDX_W + 1;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;
   logic [IDX_W-1:0] rr_ptr, gnt_idx;
   logic [IDX_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [N_BTN-1:0] grant;
   logic             found, gnt_any, pop, can_push;
   assign evt_valid = fifo_count != '0;
   assign evt_idx   = evt_valid ? mem[rd_ptr] : '0;
   assign pop       = evt_valid && evt_ready;
   assign can_push  = (fifo_count < CW'(FIFO_DEPTH)) || pop;
   // Scan pending from rr_ptr upward, wrapping at N_BTN-1; first set bit wins.
   always_comb begin
      logic [TW-1:0] t;
      t = '0;
      found = 1'b0;
      gnt_idx = '0;
      for (int j = 0; j < N_BTN; j++) begin
         t = {1'b0, rr_ptr} + TW'(j);
         if (t >= TW'(N_BTN)) t = t - TW'(N_BTN);
         if (!found && pending[t[IDX_W-1:0]]) begin
            found = 1'b1;
            gnt_idx = t[IDX_W-1:0];
         end
      end
      gnt_any = found && can_push;
      grant = gnt_any ? N_BTN'(1) << gnt_idx : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= '0;
         rr_ptr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         pending <= (pending & ~grant) | btn_pulse;
         if (gnt_any) begin
            mem[wr_ptr] <= gnt_idx;
            wr_ptr      <= wr_ptr + 1'b1;
            rr_ptr      <= (gnt_idx == IDX_W'(N_BTN-1)) ? '0 : gnt_idx + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + CW'(gnt_any) - CW'(pop);
      end
   end
`ifdef DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) drop_cnt <= '0;
      else if (|(btn_pulse & pending & ~grant) && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
   end
`endif
endmodule
